line_mem_arbiter: RTL and testbench
===================================

# line_mem_arbiter

- Shares the single 256-line × 128-bit instruction/line memory between `NUM_REQ` independent requesters (e.g. I-fetch refill and D-side refill).
- Accepts one request at a time and drives the memory's level-sensitive req/comp handshake.
- Captures the returned line and delivers it to the winning requester with a one-cycle valid pulse.
- Sits between the refill engines and the line memory.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range is 2..4.
- `ADDR_W`, default 8: line address width.
- `LINE_W`, default 128: line data width.

Ports:
- `clk`, in, 1: clock. All logic is on the rising edge.
- `reset_n`, in, 1: reset. Synchronous, active-low.
- `req_valid_i`, in, `NUM_REQ`: per-requester request. Held high until accepted.
- `req_addr_i`, in, `NUM_REQ*ADDR_W`: per-requester line address. Requester k uses slice `[k*ADDR_W +: ADDR_W]`. Stable while `req_valid_i[k]` is high.
- `req_ready_o`, out, `NUM_REQ`: accept strobe, combinational, one-hot or zero. Asserted only in IDLE.
- `rsp_valid_o`, out, `NUM_REQ`: one-cycle, one-hot response pulse.
- `rsp_data_o`, out, `LINE_W`: line data. Valid when any `rsp_valid_o` bit is high.
- `busy_o`, out, 1: high in every state except IDLE.
- `mem_req_out`, out, 1: memory request level.
- `mem_addr_out`, out, `ADDR_W`: memory line address.
- `mem_data_in`, in, `LINE_W`: memory read data.
- `mem_comp_in`, in, 1: memory completion level.

## Operation

Memory behaviour the arbiter relies on:
- On each edge where the memory samples `mem_req_out`=1, it registers `mem_comp_in`=1 and `mem_data_in`=line at `mem_addr_out`.
- On each edge where it samples `mem_req_out`=0, it registers `mem_comp_in`=0 and `mem_data_in`=0.

State machine:
- **IDLE**
  - The arbitration winner w is chosen among the set bits of `req_valid_i`.
  - `req_ready_o[w]`=1 combinationally. A request is accepted when valid && ready.
  - On accept: latch w and `req_addr_i[w]`, set `mem_req_out`<=1, set `mem_addr_out`<=addr, go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - Hold `mem_req_out`=1 and the latched address.
  - When `mem_comp_in`=1: set `rsp_data_o`<=`mem_data_in`, set `rsp_valid_o[w]`<=1, set `mem_req_out`<=0, go to DRAIN.
  - Any number of wait cycles is tolerated.
- **DRAIN**
  - Exactly one cycle.
  - `mem_req_out`=0, so the memory clears `mem_comp_in` at the end of this cycle.
  - `rsp_valid_o` is cleared. Unconditionally go to IDLE.
  - This state guarantees a stale comp is never taken as completion of the next transaction.

Output behaviour:
- `rsp_data_o` holds its last captured value until the next capture.
- `req_ready_o` is 0 outside IDLE, and is 0 for all requesters when no request is valid.
- A new `req_valid_i` edge during ISSUE/DRAIN is simply held by the requester until IDLE.

Reset values (any cycle, including mid-transaction):
- State IDLE; `mem_req_out`=0, `mem_addr_out`=0, `rsp_valid_o`=0, `rsp_data_o`=0.
- Grant pointer = `NUM_REQ`-1, so requester 0 is first in order. An in-flight transaction is discarded with no response.

## Timing

- An accept in cycle t gives `mem_req_out`=1 in t+1, `mem_comp_in`=1 in t+2, and `rsp_valid_o` in t+3 (DRAIN). IDLE is reached in t+4.
- Accept-to-response latency is 3 cycles. Peak throughput is one line per 4 cycles.
- `req_ready_o` is combinational from `req_valid_i` and the pointer. No other output is combinational.

## Configuration

- `LINE_MEM_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at (last_grant+1) mod `NUM_REQ`.
  - The pointer updates to w on accept.
  - Every persistently requesting port is served within `NUM_REQ` transactions.
- Undefined: fixed priority, where the lowest index wins. The pointer register is not implemented.

## Test plan

- **Single request:** `req_valid_i`=01, addr0=0x05 → `req_ready_o`=01 in the same cycle; `mem_addr_out`=0x05; `rsp_valid_o`=01 exactly 3 cycles after accept, with `rsp_data_o`=mem[0x05]; `busy_o` low 4 cycles after accept.
- **Simultaneous requests, RR enabled:** `req_valid_i`=11 held, addr0=0x10, addr1=0x20 → grants alternate 0,1,0,1 and responses alternate mem[0x10], mem[0x20], each 4 cycles apart.
- **Simultaneous requests, RR disabled:** `req_valid_i`=11 held → every grant goes to requester 0; requester 1 is granted only after `req_valid_i[0]` drops.
- **Memory stall:** the bench model withholds `mem_comp_in` for 5 extra cycles → `mem_req_out` stays 1 with a stable address; `rsp_valid_o` pulses exactly once, the cycle after comp is first seen.
- **Reset mid-transaction:** assert `reset_n`=0 in the ISSUE cycle → next cycle `mem_req_out`=0, `rsp_valid_o`=0, `rsp_data_o`=0, state IDLE; no response is ever issued for the aborted request. After release, requester 0 wins a 11 contention.
- **Back-to-back same port:** requester 1 re-asserts immediately after its response → no overlap; `mem_comp_in` is observed 0 in IDLE before the new ISSUE, and the new `mem_req_out` rises 4 cycles after the previous one.

Source files
------------

// File: rtl/line_mem_arbiter_if.sv
// Request/response and line-memory handshake bundle for line_mem_arbiter.
// The arbiter uses the slave modport; refill engines plus the memory sit on master.
interface line_mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int LINE_W  = 128
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [LINE_W-1:0]         rsp_data_o;
  logic                      busy_o;
  logic                      mem_req_out;
  logic [ADDR_W-1:0]         mem_addr_out;
  logic [LINE_W-1:0]         mem_data_in;
  logic                      mem_comp_in;

  modport slave (
    input  req_valid_i, req_addr_i, mem_data_in, mem_comp_in,
    output req_ready_o, rsp_valid_o, rsp_data_o, busy_o, mem_req_out, mem_addr_out
  );

  modport master (
    output req_valid_i, req_addr_i, mem_data_in, mem_comp_in,
    input  req_ready_o, rsp_valid_o, rsp_data_o, busy_o, mem_req_out, mem_addr_out
  );
endinterface

// File: rtl/line_mem_arbiter.sv
// Shares one line memory between NUM_REQ refill requesters over a level req/comp handshake.
// Define LINE_MEM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module line_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int LINE_W  = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  line_mem_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [LINE_W-1:0]    rsp_data_q, rsp_data_d;

  logic [IDX_W-1:0]     arb_win;
  logic [IDX_W-1:0]     arb_cand;
  logic                 arb_found;
  logic [ADDR_W-1:0]    arb_addr;
  logic [NUM_REQ-1:0]   ready_c;

`ifdef LINE_MEM_ARB_RR_EN
  logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

  // Winner selection: first set request bit in search order
  always_comb begin
    arb_win   = '0;
    arb_cand  = '0;
    arb_found = 1'b0;
`ifdef LINE_MEM_ARB_RR_EN
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!arb_found && bus.req_valid_i[arb_cand]) begin
        arb_win   = arb_cand;
        arb_found = 1'b1;
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_cand = IDX_W'(i);
      if (!arb_found && bus.req_valid_i[arb_cand]) begin
        arb_win   = arb_cand;
        arb_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    arb_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == arb_win) arb_addr = bus.req_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    ready_c = '0;
    if (state_q == IDLE && arb_found) ready_c[arb_win] = 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef LINE_MEM_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          win_d      = arb_win;
          mem_req_d  = 1'b1;
          mem_addr_d = arb_addr;
`ifdef LINE_MEM_ARB_RR_EN
          ptr_d      = arb_win;
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_comp_in) begin
          rsp_data_d         = bus.mem_data_in;
          rsp_valid_d[win_q] = 1'b1;
          mem_req_d          = 1'b0;
          state_d            = DRAIN;
        end
      end
      // One dead cycle lets the memory drop comp before the next ISSUE can look at it
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      win_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef LINE_MEM_ARB_RR_EN
      ptr_q       <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef LINE_MEM_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.req_ready_o  = ready_c;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.mem_req_out  = mem_req_q;
  assign bus.mem_addr_out = mem_addr_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Bench for line_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (arbitration order, fixed latency, line contents).
module tb_line_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  line_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) bus ();

  line_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [LW-1:0] mem [256];
  int stall_cfg = 0;
  int req_cnt = 0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_grant = N - 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Line memory: level handshake with an optional number of withheld comp cycles
  always @(posedge clk) begin
    if (bus.mem_req_out === 1'b1) begin
      if (req_cnt >= stall_cfg) begin
        bus.mem_comp_in <= 1'b1;
        bus.mem_data_in <= mem[bus.mem_addr_out];
      end else begin
        bus.mem_comp_in <= 1'b0;
        bus.mem_data_in <= '0;
      end
      req_cnt <= req_cnt + 1;
    end else begin
      bus.mem_comp_in <= 1'b0;
      bus.mem_data_in <= '0;
      req_cnt <= 0;
    end
  end

  function automatic int predict(input logic [N-1:0] v, input int last);
`ifdef LINE_MEM_ARB_RR_EN
    for (int d = 1; d <= N; d++) if (v[(last + d) % N]) return (last + d) % N;
`else
    for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    if (k < 0) return '0;
    return N'(1) << k;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid_i = '0;
    bus.req_addr_i = '0;
    repeat (3) step();
    vectors++; if (bus.mem_req_out !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req_out); end
    vectors++; if (bus.mem_addr_out !== 8'h00) begin miscompares++; $display("FAIL reset_mem_addr got=%h exp=00", bus.mem_addr_out); end
    vectors++; if (bus.rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid_o); end
    vectors++; if (bus.rsp_data_o !== 128'h0) begin miscompares++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data_o); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    vectors++; if (bus.req_ready_o !== 2'b00) begin miscompares++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready_o); end
    reset_n = 1'b1;
    last_grant = N - 1;
    step();
  endtask

  task automatic test_single();
    bus.req_addr_i = {8'h00, 8'h05};
    bus.req_valid_i = 2'b01;
    #1;
    vectors++; if (bus.req_ready_o !== 2'b01) begin miscompares++; $display("FAIL single_ready got=%b exp=01", bus.req_ready_o); end
    last_grant = 0;
    step(); bus.req_valid_i = 2'b00;
    vectors++; if ({bus.mem_req_out, bus.mem_addr_out} !== {1'b1, 8'h05}) begin miscompares++; $display("FAIL single_issue got=%b/%h exp=1/05", bus.mem_req_out, bus.mem_addr_out); end
    step();
    vectors++; if (bus.rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL single_early_rsp got=%b exp=00", bus.rsp_valid_o); end
    step();
    vectors++; if (bus.rsp_valid_o !== 2'b01) begin miscompares++; $display("FAIL single_rsp_valid got=%b exp=01", bus.rsp_valid_o); end
    vectors++; if (bus.rsp_data_o !== mem[8'h05]) begin miscompares++; $display("FAIL single_rsp_data got=%h exp=%h", bus.rsp_data_o, mem[8'h05]); end
    vectors++; if ({bus.busy_o, bus.mem_req_out} !== 2'b10) begin miscompares++; $display("FAIL single_drain got=%b exp=10", {bus.busy_o, bus.mem_req_out}); end
    step();
    vectors++; if ({bus.busy_o, bus.rsp_valid_o} !== 3'b000) begin miscompares++; $display("FAIL single_idle got=%b exp=000", {bus.busy_o, bus.rsp_valid_o}); end
    vectors++; if (bus.rsp_data_o !== mem[8'h05]) begin miscompares++; $display("FAIL single_hold_data got=%h exp=%h", bus.rsp_data_o, mem[8'h05]); end
  endtask

  task automatic test_contention();
    int w, t, prev_t, k;
    logic [7:0] a [2];
    a[0] = 8'h10; a[1] = 8'h20;
    reset_n = 1'b0; step(); step(); reset_n = 1'b1; last_grant = N - 1;
    bus.req_addr_i = {a[1], a[0]};
    bus.req_valid_i = 2'b11;
    prev_t = -1;
    for (int n = 0; n < 4; n++) begin
      #1;
      for (k = 0; k < 8 && bus.req_ready_o === 2'b00; k++) step();
      w = predict(2'b11, last_grant);
      t = cyc;
      vectors++; if (bus.req_ready_o !== oh(w)) begin miscompares++; $display("FAIL contend_grant%0d got=%b exp=%b", n, bus.req_ready_o, oh(w)); end
      if (prev_t >= 0) begin
        vectors++; if (t - prev_t !== 4) begin miscompares++; $display("FAIL contend_spacing%0d got=%0d exp=4", n, t - prev_t); end
      end
      prev_t = t;
      last_grant = w;
      repeat (3) step();
      vectors++; if (bus.rsp_valid_o !== oh(w)) begin miscompares++; $display("FAIL contend_rsp%0d got=%b exp=%b", n, bus.rsp_valid_o, oh(w)); end
      vectors++; if (bus.rsp_data_o !== mem[a[w]]) begin miscompares++; $display("FAIL contend_data%0d got=%h exp=%h", n, bus.rsp_data_o, mem[a[w]]); end
      step();
    end
    bus.req_valid_i = 2'b10;
    #1;
    w = predict(2'b10, last_grant);
    vectors++; if (bus.req_ready_o !== oh(w)) begin miscompares++; $display("FAIL contend_drop0 got=%b exp=%b", bus.req_ready_o, oh(w)); end
    last_grant = w;
    step(); bus.req_valid_i = 2'b00;
    repeat (4) step();
  endtask

  task automatic test_stall();
    int nrsp, rsp_at;
    stall_cfg = 5;
    bus.req_addr_i = {8'h33, 8'h00};
    bus.req_valid_i = 2'b10;
    #1;
    vectors++; if (bus.req_ready_o !== 2'b10) begin miscompares++; $display("FAIL stall_ready got=%b exp=10", bus.req_ready_o); end
    last_grant = 1;
    nrsp = 0; rsp_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) bus.req_valid_i = 2'b00;
      if (i <= 7) begin
        vectors++; if ({bus.mem_req_out, bus.mem_addr_out} !== {1'b1, 8'h33}) begin miscompares++; $display("FAIL stall_hold%0d got=%b/%h exp=1/33", i, bus.mem_req_out, bus.mem_addr_out); end
      end
      if (bus.rsp_valid_o !== 2'b00) begin nrsp++; rsp_at = i; end
    end
    vectors++; if (nrsp !== 1) begin miscompares++; $display("FAIL stall_rsp_count got=%0d exp=1", nrsp); end
    vectors++; if (rsp_at !== 8) begin miscompares++; $display("FAIL stall_rsp_cycle got=%0d exp=8", rsp_at); end
    vectors++; if (bus.rsp_data_o !== mem[8'h33]) begin miscompares++; $display("FAIL stall_data got=%h exp=%h", bus.rsp_data_o, mem[8'h33]); end
    stall_cfg = 0;
  endtask

  task automatic test_reset_mid();
    int nrsp;
    bus.req_addr_i = {8'h20, 8'h44};
    bus.req_valid_i = 2'b01;
    #1;
    vectors++; if (bus.req_ready_o !== oh(predict(2'b01, last_grant))) begin miscompares++; $display("FAIL rmid_ready got=%b exp=01", bus.req_ready_o); end
    step();
    bus.req_valid_i = 2'b00;
    vectors++; if (bus.mem_req_out !== 1'b1) begin miscompares++; $display("FAIL rmid_issue got=%b exp=1", bus.mem_req_out); end
    reset_n = 1'b0;
    step();
    vectors++; if ({bus.mem_req_out, bus.busy_o, bus.rsp_valid_o} !== 4'b0000) begin miscompares++; $display("FAIL rmid_ctrl got=%b exp=0000", {bus.mem_req_out, bus.busy_o, bus.rsp_valid_o}); end
    vectors++; if (bus.rsp_data_o !== 128'h0) begin miscompares++; $display("FAIL rmid_data got=%h exp=0", bus.rsp_data_o); end
    reset_n = 1'b1;
    last_grant = N - 1;
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.rsp_valid_o !== 2'b00) nrsp++;
    end
    vectors++; if (nrsp !== 0) begin miscompares++; $display("FAIL rmid_ghost_rsp got=%0d exp=0", nrsp); end
    bus.req_addr_i = {8'h20, 8'h10};
    bus.req_valid_i = 2'b11;
    #1;
    vectors++; if (bus.req_ready_o !== 2'b01) begin miscompares++; $display("FAIL rmid_first_grant got=%b exp=01", bus.req_ready_o); end
    last_grant = 0;
    step(); bus.req_valid_i = 2'b00;
    repeat (2) step();
    vectors++; if (bus.rsp_data_o !== mem[8'h10]) begin miscompares++; $display("FAIL rmid_after_data got=%h exp=%h", bus.rsp_data_o, mem[8'h10]); end
    step();
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    bus.req_addr_i = {8'h7A, 8'h00};
    bus.req_valid_i = 2'b10;
    #1;
    vectors++; if (bus.req_ready_o !== 2'b10) begin miscompares++; $display("FAIL b2b_ready1 got=%b exp=10", bus.req_ready_o); end
    t1 = cyc; last_grant = 1;
    step(); bus.req_valid_i = 2'b00;
    repeat (2) step();
    vectors++; if (bus.rsp_valid_o !== 2'b10) begin miscompares++; $display("FAIL b2b_rsp1 got=%b exp=10", bus.rsp_valid_o); end
    step();
    vectors++; if ({bus.mem_comp_in, bus.mem_req_out, bus.busy_o} !== 3'b000) begin miscompares++; $display("FAIL b2b_idle_gap got=%b exp=000", {bus.mem_comp_in, bus.mem_req_out, bus.busy_o}); end
    bus.req_valid_i = 2'b10;
    #1;
    vectors++; if (bus.req_ready_o !== 2'b10) begin miscompares++; $display("FAIL b2b_ready2 got=%b exp=10", bus.req_ready_o); end
    t2 = cyc;
    vectors++; if (t2 - t1 !== 4) begin miscompares++; $display("FAIL b2b_spacing got=%0d exp=4", t2 - t1); end
    step(); bus.req_valid_i = 2'b00;
    vectors++; if (bus.mem_req_out !== 1'b1) begin miscompares++; $display("FAIL b2b_reissue got=%b exp=1", bus.mem_req_out); end
    repeat (2) step();
    vectors++; if (bus.rsp_data_o !== mem[8'h7A]) begin miscompares++; $display("FAIL b2b_data2 got=%h exp=%h", bus.rsp_data_o, mem[8'h7A]); end
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] pat;
    logic [7:0] a [2];
    int w, t, st, guard, k;
    for (int r = 0; r < 40; r++) begin
      pat = N'($urandom_range(1, 3));
      a[0] = 8'($urandom); a[1] = 8'($urandom);
      st = int'($urandom_range(0, 3));
      stall_cfg = st;
      bus.req_addr_i = {a[1], a[0]};
      guard = 0;
      while (pat != '0 && guard < 4) begin
        guard++;
        bus.req_valid_i = pat;
        #1;
        w = predict(pat, last_grant);
        vectors++;
        if (bus.req_ready_o !== oh(w)) begin
          miscompares++; $display("FAIL rand_grant r%0d got=%b exp=%b", r, bus.req_ready_o, oh(w));
          pat = '0; bus.req_valid_i = '0; repeat (12) step();
        end else begin
          t = cyc; last_grant = w; pat[w] = 1'b0;
          step(); bus.req_valid_i = pat;
          for (k = 0; k < 20 && bus.rsp_valid_o === 2'b00; k++) step();
          vectors++; if (cyc - t !== 3 + st) begin miscompares++; $display("FAIL rand_latency r%0d got=%0d exp=%0d", r, cyc - t, 3 + st); end
          vectors++; if (bus.rsp_valid_o !== oh(w)) begin miscompares++; $display("FAIL rand_rsp r%0d got=%b exp=%b", r, bus.rsp_valid_o, oh(w)); end
          vectors++; if (bus.rsp_data_o !== mem[a[w]]) begin miscompares++; $display("FAIL rand_data r%0d got=%h exp=%h", r, bus.rsp_data_o, mem[a[w]]); end
          step();
          vectors++; if ({bus.rsp_valid_o, bus.busy_o} !== 3'b000) begin miscompares++; $display("FAIL rand_pulse r%0d got=%b exp=000", r, {bus.rsp_valid_o, bus.busy_o}); end
        end
      end
    end
    bus.req_valid_i = '0;
    stall_cfg = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid_i = '0;
    bus.req_addr_i = '0;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end
endmodule
